// File: rtl/tt_um_ternary_weight_loader_if.sv
// Weight-bus interface between the weight loader and its producer/consumer.
//   master : drives load_start, data_in, data_valid, swap_ok; observes the rest
//   slave  : the loader itself; drives data_ready, W_out, w_valid, load_done, code_err
// Handshake: a data beat transfers on a rising clk edge where data_valid and
// data_ready are both 1; data_ready never depends on data_valid.
interface tt_um_ternary_weight_loader_if #(
    parameter int BitWidth = 8,
    parameter int WBits    = 256
);
    logic                load_start;
    logic [BitWidth-1:0] data_in;
    logic                data_valid;
    logic                data_ready;
    logic                swap_ok;
    logic [WBits-1:0]    W_out;
    logic                w_valid;
    logic                load_done;
    logic                code_err;

    modport master (
        output load_start, data_in, data_valid, swap_ok,
        input  data_ready, W_out, w_valid, load_done, code_err
    );

    modport slave (
        input  load_start, data_in, data_valid, swap_ok,
        output data_ready, W_out, w_valid, load_done, code_err
    );
endinterface

// File: rtl/tt_um_ternary_weight_loader.sv
// Ternary weight loader: receives the weight image one byte per handshake,
// replaces illegal 2'b10 codes with 2'b00 (flagging code_err), builds the image
// in a shadow register and copies it to W_out in one cycle once the multiplier
// reports a safe boundary (swap_ok).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         slave side of tt_um_ternary_weight_loader_if
//               (load_start, data_in, data_valid, data_ready, swap_ok,
//                W_out, w_valid, load_done, code_err)
//   state_dbg   current FSM state (0 IDLE, 1 LOAD, 2 COMMIT)
module tt_um_ternary_weight_loader #(
    parameter int InLen    = 16,
    parameter int OutLen   = 8,
    parameter int BitWidth = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    tt_um_ternary_weight_loader_if.slave       bus,
    output logic [1:0]                         state_dbg
);
    localparam int WBits  = 2 * InLen * OutLen;
    localparam int NBytes = WBits / BitWidth;
    localparam int CntW   = (NBytes > 1) ? $clog2(NBytes) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NBytes - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CntW-1:0]     cnt_q;
    logic [WBits-1:0]    shadow_q;
    logic [WBits-1:0]    w_out_q;
    logic                w_valid_q;
    logic                code_err_q;
    logic [BitWidth-1:0] clean_byte;
    logic                byte_err;
    logic                beat;
    logic                last_beat;
    logic                commit;

    // load_start outranks any data beat arriving in the same cycle.
    assign beat      = (state_q == LOAD) && bus.data_valid && !bus.load_start;
    assign last_beat = beat && (cnt_q == LastCnt);

    // Sanitise every 2-bit field of the incoming byte.
    always_comb begin
        clean_byte = bus.data_in;
        byte_err   = 1'b0;
        for (int i = 0; i < BitWidth / 2; i++) begin
            if (bus.data_in[2*i +: 2] == 2'b10) begin
                clean_byte[2*i +: 2] = 2'b00;
                byte_err             = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_start) state_d = LOAD;
            end
            LOAD: begin
                if (bus.load_start) state_d = LOAD;
                else if (last_beat) state_d = COMMIT;
            end
            COMMIT: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                end else if (bus.swap_ok) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shadow_q   <= '0;
            w_out_q    <= '0;
            w_valid_q  <= 1'b0;
            code_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (bus.load_start) begin
                cnt_q      <= '0;
                code_err_q <= 1'b0;
            end else if (beat) begin
                shadow_q[int'(cnt_q) * BitWidth +: BitWidth] <= clean_byte;
                // Counter parks on the last index; entering LOAD clears it.
                if (!last_beat) cnt_q <= cnt_q + 1'b1;
                if (byte_err) code_err_q <= 1'b1;
            end
            if (commit) begin
                w_out_q   <= shadow_q;
                w_valid_q <= 1'b1;
            end
        end
    end

    assign bus.data_ready = (state_q == LOAD);
    assign bus.load_done  = commit;
    assign bus.W_out      = w_out_q;
    assign bus.w_valid    = w_valid_q;
    assign bus.code_err   = code_err_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_tt_um_ternary_weight_loader.sv
module tb_tt_um_ternary_weight_loader;
    localparam int WBits  = 256;
    localparam int NBytes = 32;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    tt_um_ternary_weight_loader_if #(.BitWidth(8), .WBits(WBits)) bus ();

    tt_um_ternary_weight_loader #(.InLen(16), .OutLen(8), .BitWidth(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [WBits:0]  exp_q[$];     // {code_err, W_out}
    int              n_checks = 0;
    int              n_pass   = 0;
    int              done_cnt = 0;
    int              done_cyc = 0;
    bit              mon_busy = 0;
    logic [7:0]      img [NBytes];

    task automatic chk(input string name, input logic [WBits-1:0] act, input logic [WBits-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: act=%h exp=%h", name, act, exp);
    endtask

    always @(negedge clk) begin
        logic [WBits:0] e;
        if (rst_n && bus.load_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_load_done", 1, 0);
            end else begin
                mon_busy = 1;
                e = exp_q.pop_front();
                @(negedge clk);
                chk("sb_w_out", bus.W_out, e[WBits-1:0]);
                chk("sb_w_valid", WBits'(bus.w_valid), 1);
                chk("sb_code_err", WBits'(bus.code_err), WBits'(e[WBits]));
                mon_busy = 0;
            end
        end
    end

    // ---------------- model ----------------
    function automatic logic [7:0] san(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < 4; i++)
            if (b[2*i +: 2] == 2'b10) r[2*i +: 2] = 2'b00;
        return r;
    endfunction

    function automatic logic has_err(input logic [7:0] b);
        logic e;
        e = 1'b0;
        for (int i = 0; i < 4; i++)
            if (b[2*i +: 2] == 2'b10) e = 1'b1;
        return e;
    endfunction

    // ---------------- drivers ----------------
    task automatic pulse_start();
        bus.load_start = 1'b1;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
    endtask

    task automatic fill_img(input logic [7:0] b);
        for (int k = 0; k < NBytes; k++) img[k] = b;
    endtask

    task automatic send_img(input int n, input bit rand_valid);
        int   k;
        int   budget;
        logic acc;
        k = 0;
        budget = 0;
        while (k < n && budget < 400) begin
            bus.data_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.data_in    = img[k];
            acc = bus.data_valid && bus.data_ready;
            @(posedge clk); #1;
            if (acc) k++;
            budget++;
        end
        bus.data_valid = 1'b0;
        chk("beats_accepted", WBits'(k), WBits'(n));
    endtask

    task automatic wait_sb();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || mon_busy) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("sb_drained", WBits'(exp_q.size() == 0 && !mon_busy), 1);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        string      name;
        logic [7:0] fill;
        logic [7:0] exp_byte;
        logic       exp_err;
        bit         rand_valid;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [WBits-1:0] exp_w;
        logic [WBits-1:0] last_w;
        logic             exp_e;
        int               start_cyc;
        int               d0;

        vecs[0] = '{"fill_5d", 8'h5D, 8'h5D, 1'b0, 1'b0};
        vecs[1] = '{"fill_aa", 8'hAA, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{"fill_ff", 8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{"fill_9c", 8'h9C, 8'h1C, 1'b1, 1'b0};
        vecs[4] = '{"fill_11", 8'h11, 8'h11, 1'b0, 1'b1};
        vecs[5] = '{"fill_26", 8'h26, 8'h04, 1'b1, 1'b1};
        vecs[6] = '{"fill_00", 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{"fill_37", 8'h37, 8'h37, 1'b0, 1'b0};

        rst_n          = 1'b0;
        bus.load_start = 1'b0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.swap_ok    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w_out", bus.W_out, 0);
        chk("rst_w_valid", WBits'(bus.w_valid), 0);
        chk("rst_data_ready", WBits'(bus.data_ready), 0);
        chk("rst_load_done", WBits'(bus.load_done), 0);
        chk("rst_code_err", WBits'(bus.code_err), 0);
        chk("rst_state", WBits'(state_dbg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Incrementing bytes 0x00..0x1F; illegal codes must be zeroed.
        exp_e = 1'b0;
        for (int k = 0; k < NBytes; k++) begin
            img[k] = 8'(k);
            exp_w[8*k +: 8] = san(8'(k));
            exp_e = exp_e | has_err(8'(k));
        end
        exp_q.push_back({exp_e, exp_w});
        start_cyc = cyc;
        pulse_start();
        send_img(NBytes, 1'b0);
        wait_sb();
        chk("done_latency", WBits'(done_cyc - start_cyc), 33);
        last_w = exp_w;

        // Table of uniform fills.
        for (int v = 0; v < 8; v++) begin
            fill_img(vecs[v].fill);
            exp_w = {NBytes{vecs[v].exp_byte}};
            exp_q.push_back({vecs[v].exp_err, exp_w});
            d0 = done_cnt;
            pulse_start();
            send_img(NBytes, vecs[v].rand_valid);
            wait_sb();
            chk({vecs[v].name, "_done_count"}, WBits'(done_cnt - d0), 1);
            last_w = exp_w;
        end

        // Commit held off by swap_ok; extra data beats must be ignored.
        bus.swap_ok = 1'b0;
        fill_img(8'h5D);
        exp_q.push_back({1'b0, {NBytes{8'h5D}}});
        pulse_start();
        send_img(NBytes, 1'b0);
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h00;
        for (int i = 0; i < 10; i++) begin
            chk("hold_w_out", bus.W_out, last_w);
            chk("hold_data_ready", WBits'(bus.data_ready), 0);
            chk("hold_load_done", WBits'(bus.load_done), 0);
            chk("hold_state", WBits'(state_dbg), 2);
            @(posedge clk); #1;
        end
        bus.data_valid = 1'b0;
        bus.swap_ok    = 1'b1;
        #1;
        chk("swap_load_done", WBits'(bus.load_done), 1);
        wait_sb();
        last_w = {NBytes{8'h5D}};

        // Restart after 12 bytes; a beat alongside load_start is dropped.
        d0 = done_cnt;
        fill_img(8'hAA);
        pulse_start();
        send_img(12, 1'b0);
        chk("abort_code_err_set", WBits'(bus.code_err), 1);
        exp_q.push_back({1'b0, {WBits{1'b1}}});
        bus.load_start = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h00;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        bus.data_valid = 1'b0;
        chk("abort_code_err_clr", WBits'(bus.code_err), 0);
        chk("abort_state", WBits'(state_dbg), 1);
        chk("abort_w_out_kept", bus.W_out, last_w);
        fill_img(8'hFF);
        send_img(NBytes, 1'b0);
        wait_sb();
        chk("abort_done_count", WBits'(done_cnt - d0), 1);

        // Asynchronous reset in the middle of a load.
        fill_img(8'h11);
        pulse_start();
        send_img(20, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_w_out", bus.W_out, 0);
        chk("mid_rst_w_valid", WBits'(bus.w_valid), 0);
        chk("mid_rst_data_ready", WBits'(bus.data_ready), 0);
        chk("mid_rst_code_err", WBits'(bus.code_err), 0);
        chk("mid_rst_state", WBits'(state_dbg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h11;
        repeat (40) @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        chk("no_start_w_valid", WBits'(bus.w_valid), 0);
        chk("no_start_done", WBits'(done_cnt - d0), 0);
        chk("no_start_state", WBits'(state_dbg), 0);
        exp_q.push_back({1'b0, {NBytes{8'h11}}});
        pulse_start();
        send_img(NBytes, 1'b1);
        wait_sb();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
